// File: rtl/mem_user_dumper_if.sv
// Bundles the memory user read port, the dump request inputs and the word output stream.
// The dumper connects through master; the debug/readout side and the memory connect through slave.
interface mem_user_dumper_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] start_adr;
  logic [ADDR_W-1:0] end_adr;
  logic [ADDR_W-1:0] User_in_check;
  logic [DATA_W-1:0] User_readData;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_adr;
  logic              dump_valid;
  logic              dump_ready;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  modport master (
    input  start, abort, start_adr, end_adr, User_readData, dump_ready,
    output User_in_check, dump_data, dump_adr, dump_valid, busy, done, checksum
  );

  modport slave (
    output start, abort, start_adr, end_adr, User_readData, dump_ready,
    input  User_in_check, dump_data, dump_adr, dump_valid, busy, done, checksum
  );
endinterface

// File: rtl/mem_user_dumper.sv
// Read-side master for the memory user inspection port: sweeps an even-aligned word range,
// presents each word on a valid/ready stream with its address and keeps a running checksum.
module mem_user_dumper #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 16,
  parameter int STEP      = 2,
  parameter int LAST_ADDR = 48
) (
  input logic                clk,
  input logic                reset,
  mem_user_dumper_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ADDR, PRESENT, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] STEP_V    = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] EVEN_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};

  state_t            state;
  state_t            nextState;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] endAdr;
  logic [ADDR_W-1:0] checkAdr;
  logic [ADDR_W-1:0] dumpAdr;
  logic [DATA_W-1:0] dumpData;
  logic [DATA_W-1:0] sum;

  logic [ADDR_W-1:0] startAligned;
  logic [ADDR_W-1:0] endAligned;
  logic [ADDR_W-1:0] endClamped;
  logic              startAccept;
  logic              handshake;
  logic              lastWord;
  logic              emptyRange;

  assign startAligned = bus.start_adr & EVEN_MASK;
  assign endAligned   = bus.end_adr & EVEN_MASK;
  assign endClamped   = (endAligned > LAST) ? LAST : endAligned;
  assign emptyRange   = startAligned > endClamped;

  // abort outranks both a fresh start and a pending handshake
  assign startAccept  = (state == IDLE) && bus.start && !bus.abort;
  assign handshake    = (state == PRESENT) && bus.dump_ready && !bus.abort;
  assign lastWord     = (cur == endAdr);

  // NOTE: nextState gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (bus.start && !bus.abort) nextState = emptyRange ? DONE : ADDR;
      ADDR:    nextState = PRESENT;
      PRESENT: if (bus.dump_ready) nextState = lastWord ? DONE : ADDR;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (bus.abort && state != IDLE) nextState = IDLE;
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur      <= '0;
      endAdr   <= '0;
      checkAdr <= '0;
      dumpAdr  <= '0;
      dumpData <= '0;
      sum      <= '0;
    end else begin
      if (startAccept) begin
        cur    <= startAligned;
        endAdr <= endClamped;
        sum    <= '0;
        // the port address only moves when a word will actually be read
        if (!emptyRange) checkAdr <= startAligned;
      end
      if (state == ADDR) begin
        dumpData <= bus.User_readData;
        dumpAdr  <= cur;
      end
      if (handshake) begin
        sum <= sum + dumpData;
        // equality is tested before stepping, so cur never runs past the clamped end
        if (!lastWord) begin
          cur      <= cur + STEP_V;
          checkAdr <= cur + STEP_V;
        end
      end
    end
  end

  assign bus.User_in_check = checkAdr;
  assign bus.dump_data     = dumpData;
  assign bus.dump_adr      = dumpAdr;
  assign bus.dump_valid    = (state == PRESENT);
  assign bus.busy          = (state != IDLE);
  assign bus.done          = (state == DONE);
  assign bus.checksum      = sum;

endmodule
